// File: rtl/data_mem_interface_pkg.sv
// Shared types and constants for the data-memory load/store bridge.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_t;

  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam logic [3:0] WSTRB_NONE = 4'h0;

endpackage

// File: rtl/data_mem_interface_if.sv
// Ready/ack data-memory bus between the load/store bridge and memory.
interface data_mem_interface_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/data_mem_interface_byte_lane.sv
// Byte-lane steering: store replication/strobes and zero-extended load lane select.
module byte_lane_unit
  import mem_if_pkg::*;
(
  input  logic        byte_access,
  input  logic        we,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0] lane_byte;

  always_comb begin
    wdata = byte_access ? {4{store_data[7:0]}} : store_data;

    if (!we)
      wstrb = WSTRB_NONE;
    else if (byte_access)
      wstrb = 4'b0001 << lane;
    else
      wstrb = WSTRB_WORD;

    lane_byte = load_word[7:0];
    case (lane)
      2'd0: lane_byte = load_word[7:0];
      2'd1: lane_byte = load_word[15:8];
      2'd2: lane_byte = load_word[23:16];
      2'd3: lane_byte = load_word[31:24];
      default: lane_byte = load_word[7:0];
    endcase

    load_data = byte_access ? {24'h0, lane_byte} : load_word;
  end

endmodule

// File: rtl/data_mem_interface.sv
// Multi-cycle load/store bridge: latches a core memory access, runs it on the
// ready/ack bus with timeout and misalignment faults, and stalls the core meanwhile.
module data_mem_interface
  import mem_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        byte_access,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        fault,
  data_mem_interface_if.master bus
);

  localparam logic [7:0] TERMINAL = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_byte;
  logic        lat_we;
  logic [31:0] rdata_cap;
  logic [7:0]  cnt;
  logic [31:0] load_data;

  logic access;
  logic misaligned;

  assign access     = mem_read | mem_write;
  assign misaligned = !byte_access && (addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_byte    <= 1'b0;
      lat_we      <= 1'b0;
      rdata_cap   <= '0;
      cnt         <= '0;
      fault       <= 1'b0;
      bus.mem_req <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            lat_addr  <= addr;
            lat_wdata <= write_data;
            lat_byte  <= byte_access;
            lat_we    <= mem_write;
            cnt       <= '0;
            if (misaligned) begin
              fault <= 1'b1;
              state <= DONE;
            end else begin
              bus.mem_req <= 1'b1;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          // Ack has priority over the terminal count in the same cycle.
          if (bus.mem_ack) begin
            rdata_cap   <= bus.mem_rdata;
            bus.mem_req <= 1'b0;
            state       <= DONE;
          end else if (cnt == TERMINAL) begin
            bus.mem_req <= 1'b0;
            fault       <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  byte_lane_unit u_byte_lane (
    .byte_access (lat_byte),
    .we          (lat_we),
    .lane        (lat_addr[1:0]),
    .store_data  (lat_wdata),
    .load_word   (rdata_cap),
    .wdata       (bus.mem_wdata),
    .wstrb       (bus.mem_wstrb),
    .load_data   (load_data)
  );

  assign bus.mem_addr = {lat_addr[31:2], 2'b00};
  assign bus.mem_we   = lat_we;

  always_comb begin
    stall = ((state == IDLE) && access) || (state == REQ);
    read_data = '0;
    if ((state == DONE) && !fault && !lat_we)
      read_data = load_data;
  end

endmodule

// File: tb/tb_data_mem_interface.sv
// Randomized scoreboard bench for the load/store bridge with a byte-level reference memory.
module tb_data_mem_interface;

  localparam int T = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    bit          is_load;
    int          stalls;
    int          reqs;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        byte_access = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        stall;
  logic        fault;
  logic        force_ack = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int n_done = 0;

  exp_t sb_q[$];
  bus_t bus_q[$];
  logic [7:0]  ref_mem[int unsigned];
  logic [31:0] bus_mem[int unsigned];

  data_mem_interface_if mem_bus ();

  data_mem_interface #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .byte_access (byte_access),
    .addr        (addr),
    .write_data  (write_data),
    .read_data   (read_data),
    .stall       (stall),
    .fault       (fault),
    .bus         (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] bus_word(input int unsigned wa);
    return bus_mem.exists(wa) ? bus_mem[wa] : 32'h0;
  endfunction

  task automatic preload(input int unsigned a, input logic [31:0] w);
    bus_mem[a / 4] = w;
    for (int i = 0; i < 4; i++) ref_mem[a + i] = w[8*i +: 8];
  endtask

  // Reference: each access is a byte-addressed memory operation with spec latencies.
  task automatic access(input bit rd, input bit wr, input bit byt,
                        input logic [31:0] a, input logic [31:0] d, input int delay);
    exp_t e;
    bus_t b;
    int lane;
    bit to;
    int c;
    lane = int'(a % 4);
    e.is_load = !wr;
    e.rdata = '0;
    if (!byt && lane != 0) begin
      e.fault = 1'b1;
      e.stalls = 1;
      e.reqs = 0;
    end else begin
      to = (delay >= T);
      e.fault = to;
      e.reqs = to ? T : delay + 1;
      e.stalls = e.reqs + 1;
      b.addr = a - 32'(lane);
      b.we = wr;
      b.wdata = byt ? {4{d[7:0]}} : d;
      b.wstrb = '0;
      if (wr) begin
        if (byt) b.wstrb[lane] = 1'b1;
        else b.wstrb = 4'hF;
      end
      b.delay = delay;
      bus_q.push_back(b);
      if (wr && !to) begin
        if (byt) ref_mem[a] = d[7:0];
        else for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
      end
      if (!wr && !to) begin
        if (byt) e.rdata = {24'h0, ref_byte(a)};
        else e.rdata = {ref_byte(a + 3), ref_byte(a + 2), ref_byte(a + 1), ref_byte(a)};
      end
    end
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    mem_read = rd;
    mem_write = wr;
    byte_access = byt;
    addr = a;
    write_data = d;
    c = 0;
    @(negedge clk);
    do begin
      @(negedge clk);
      c++;
    end while (stall && c < 40);
    if (stall) chk("access_completes", 32'(stall), 32'h0);
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Memory responder: checks bus requests, acks after the scheduled delay.
  initial begin
    bus_t cur;
    logic [31:0] snap_addr, snap_wdata;
    logic snap_we;
    logic [3:0] snap_wstrb;
    int k;
    logic [31:0] w;
    k = 0;
    cur.delay = 999;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_bus.mem_req && !reset) begin
        if (k == 0) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_req", 32'(mem_bus.mem_req), 32'h0);
            cur.delay = 999;
          end else begin
            cur = bus_q.pop_front();
            chk("bus_addr", mem_bus.mem_addr, cur.addr);
            chk("bus_we", 32'(mem_bus.mem_we), 32'(cur.we));
            chk("bus_wstrb", 32'(mem_bus.mem_wstrb), 32'(cur.wstrb));
            if (cur.we) chk("bus_wdata", mem_bus.mem_wdata, cur.wdata);
          end
          snap_addr = mem_bus.mem_addr;
          snap_we = mem_bus.mem_we;
          snap_wdata = mem_bus.mem_wdata;
          snap_wstrb = mem_bus.mem_wstrb;
        end else begin
          chk("bus_stable_addr", mem_bus.mem_addr, snap_addr);
          chk("bus_stable_wdata", mem_bus.mem_wdata, snap_wdata);
          chk("bus_stable_ctl", {27'h0, snap_we, snap_wstrb},
              {27'h0, mem_bus.mem_we, mem_bus.mem_wstrb});
        end
        if (k == cur.delay) begin
          mem_bus.mem_ack = 1'b1;
          mem_bus.mem_rdata = bus_word(mem_bus.mem_addr / 4);
          if (mem_bus.mem_we) begin
            w = bus_word(mem_bus.mem_addr / 4);
            for (int i = 0; i < 4; i++)
              if (mem_bus.mem_wstrb[i]) w[8*i +: 8] = mem_bus.mem_wdata[8*i +: 8];
            bus_mem[mem_bus.mem_addr / 4] = w;
          end
        end else begin
          mem_bus.mem_ack = 1'b0;
          mem_bus.mem_rdata = $urandom;
        end
        k++;
      end else begin
        k = 0;
        mem_bus.mem_ack = force_ack | ($urandom_range(0, 3) == 0);
        mem_bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: a DONE cycle is the first non-stalled cycle after stalled ones.
  initial begin
    exp_t e;
    bit prev_stall;
    int sc, rc;
    prev_stall = 0;
    sc = 0;
    rc = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
        sc = 0;
        rc = 0;
      end else if (stall) begin
        sc++;
        if (mem_bus.mem_req) rc++;
        chk("busy_fault", 32'(fault), 32'h0);
        chk("busy_rdata", read_data, 32'h0);
        prev_stall = 1;
      end else if (prev_stall) begin
        n_done++;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(n_done), 32'h0);
        end else begin
          e = sb_q.pop_front();
          chk("done_fault", 32'(fault), 32'(e.fault));
          if (e.is_load) chk("done_rdata", read_data, e.rdata);
          chk("stall_cycles", 32'(sc), 32'(e.stalls));
          chk("req_cycles", 32'(rc), 32'(e.reqs));
          chk("done_req", 32'(mem_bus.mem_req), 32'h0);
        end
        sc = 0;
        rc = 0;
        prev_stall = 0;
      end else begin
        chk("idle_fault", 32'(fault), 32'h0);
        chk("idle_rdata", read_data, 32'h0);
        chk("idle_req", 32'(mem_bus.mem_req), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    int done_before;
    #1 reset = 1'b1;
    #2;
    chk("rst_req", 32'(mem_bus.mem_req), 32'h0);
    chk("rst_we", 32'(mem_bus.mem_we), 32'h0);
    chk("rst_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_wdata", mem_bus.mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(mem_bus.mem_wstrb), 32'h0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    preload(32'h104, 32'hDEADBEEF);
    preload(32'h300, 32'h11223344);
    access(1, 0, 0, 32'h104, 32'h0, 0);
    access(0, 1, 1, 32'h203, 32'h000000A5, 3);
    access(1, 0, 1, 32'h302, 32'h0, 1);
    access(0, 1, 0, 32'h101, 32'h12345678, 0);
    access(1, 0, 0, 32'h104, 32'h0, T);
    access(1, 0, 0, 32'h104, 32'h0, T - 1);
    access(1, 0, 1, 32'h203, 32'h0, 0);
    access(1, 1, 0, 32'h208, 32'hCAFEF00D, 0);
    access(1, 0, 0, 32'h208, 32'h0, 2);
    access(1, 0, 0, 32'h20A, 32'h0, 0);
    idle_cycles(2);

    for (int n = 0; n < 80; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a = 32'h400 + 32'($urandom_range(0, 31));
      access(op != 1, op != 0, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    // Reset in the second REQ cycle abandons the access; a later ack is ignored.
    bus_q.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0, wstrb: 4'h0, delay: 999});
    @(posedge clk);
    #1;
    mem_read = 1'b1;
    mem_write = 1'b0;
    byte_access = 1'b0;
    addr = 32'h500;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("req_before_reset", 32'(mem_bus.mem_req), 32'h1);
    reset = 1'b1;
    mem_read = 1'b0;
    #1;
    chk("req_after_reset", 32'(mem_bus.mem_req), 32'h0);
    chk("stall_after_reset", 32'(stall), 32'h0);
    done_before = n_done;
    @(negedge clk);
    reset = 1'b0;
    force_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("late_ack_stall", 32'(stall), 32'h0);
    end
    force_ack = 1'b0;
    chk("late_ack_no_done", 32'(n_done), 32'(done_before));

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    chk("bus_drained", 32'(bus_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_interface.md
# data_mem_interface

Multi-cycle load/store bridge that sits directly downstream of the core datapath. It takes the datapath's ALU-computed data address, store data and the controller's memory-access strobes, and drives a ready/ack data-memory bus. It returns load data to the datapath's result mux and stalls the core for the duration of every access. It also handles byte lanes (LDRB/STRB), misalignment faults and bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of REQ cycles without `mem_ack` before the access is aborted; legal range 1..255.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `mem_read`  in  1  load requested by the current instruction.
- `mem_write`  in  1  store requested by the current instruction.
- `byte_access`  in  1  1 = byte (LDRB/STRB), 0 = word.
- `addr`  in  32  data address from the datapath.
- `write_data`  in  32  store data from the datapath.
- `read_data`  out  32  load result to the datapath; valid in DONE only.
- `stall`  out  1  hold PC and suppress register write this cycle.
- `fault`  out  1  one-cycle pulse in DONE when the access aborted.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  bus write enable.
- `mem_addr`  out  32  word-aligned bus address, bits [1:0] = 0.
- `mem_wdata`  out  32  bus write data.
- `mem_wstrb`  out  4  byte-lane write strobes.
- `mem_ack`  in  1  bus completes the request this cycle.
- `mem_rdata`  in  32  bus read data; valid when `mem_ack` = 1.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, access pending (`mem_read | mem_write`):
  - `stall` = 1, combinational, in the same cycle.
  - Latch the address, write data, `byte_access`, and we = `mem_write`. `mem_write` wins if both strobes are high.
  - Misaligned word access (not byte and `addr[1:0]` != 0): go to DONE with the fault flag set. No bus request is issued.
  - Otherwise go to REQ.
- REQ:
  - `mem_req` = 1 and all bus outputs are driven from registers; they hold stable until ack.
  - `stall` = 1.
  - The timeout counter starts at 0 on REQ entry and increments each REQ cycle without ack.
  - `mem_ack` = 1: capture `mem_rdata`, go to DONE.
  - Counter reaches `TIMEOUT_CYCLES` - 1 without ack: drop `mem_req` next cycle, go to DONE with fault.
  - An ack arriving in the same cycle as the timeout terminal count wins; no fault.
- DONE:
  - `stall` = 0, so the core retires the instruction.
  - `read_data` = load result, or 0 on fault.
  - `fault` = latched flag.
  - Return to IDLE unconditionally, so the same instruction's strobes are not re-sampled.
- No access in IDLE: `stall` = 0, `read_data` = 0, bus idle.
- Byte store:
  - `mem_wdata` = `write_data[7:0]` replicated 4×.
  - `mem_wstrb` = 4'b0001 << `addr[1:0]`.
- Word store: `mem_wstrb` = 4'hF, `mem_wdata` = `write_data`.
- Loads: `mem_wstrb` = 0.
- Byte load: `read_data` = {24'h0, lane `addr[1:0]` of captured data}, zero-extended.
- Word load: captured word as-is.

## Timing
- Reset values: state IDLE, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `mem_wstrb` 0, `read_data` 0, `fault` 0, `stall` 0 (no access pending), counter 0.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronously). The interrupted bus transaction is abandoned, and a late ack is ignored in IDLE.
- Minimum access (ack in the first REQ cycle): 3 cycles (IDLE, REQ, DONE), of which 2 are stall cycles.
- An ack on REQ cycle k gives DONE on cycle k+1.
- Timeout: exactly `TIMEOUT_CYCLES` REQ cycles, then DONE.
- Misaligned fault: 2 cycles (IDLE, DONE).
- `mem_ack` outside REQ is ignored.

## Structure
- Package `mem_if_pkg`: `mem_state_t` enum {IDLE, REQ, DONE}, and constants `WSTRB_WORD` = 4'hF and `WSTRB_NONE` = 4'h0.
- Sub-module `byte_lane_unit`: combinational. It generates the store-data replication and strobes, and does the load lane select with zero-extension. It is used once on the latched request.

## Test plan
- Word load, addr 0x104, ack on the first REQ cycle with rdata 0xDEADBEEF:
  - `stall` is 1,1,0.
  - DONE `read_data` = 0xDEADBEEF.
  - `mem_addr` = 0x104, `mem_we` = 0.
- Byte store, addr 0x203, data 0x000000A5:
  - `mem_wdata` = 0xA5A5A5A5, `mem_wstrb` = 4'b1000, `mem_addr` = 0x200.
  - Bus signals stay stable across 3 wait cycles until ack.
- Byte load, addr 0x302, rdata 0x11223344: `read_data` = 0x00000022.
- Word store to 0x101: no `mem_req` ever; DONE on cycle 2 with `fault` = 1 and `stall` = 0.
- `TIMEOUT_CYCLES` = 4, no ack:
  - `mem_req` high for exactly 4 cycles, then DONE with `fault` = 1 and `read_data` = 0.
  - Repeat with ack on the 4th REQ cycle: no fault.
- `reset` pulsed in the second REQ cycle:
  - `mem_req` is 0 before the next clock edge; state is IDLE.
  - An ack after release is ignored: `stall` = 0 and no DONE.
